// File: rtl/arm_instr_encoder.sv
// Turns calculator requests into a burst of ARM machine words (MOV a, MOV b, ALU op, optional STR),
// streamed over a valid/ready handshake toward the processor's instruction-injection port.
module arm_instr_encoder #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [7:0]        req_a,
   input  logic [7:0]        req_b,
   input  logic              req_store,
   input  logic [ADDR_W-1:0] req_addr,
   output logic [31:0]       instr,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic              done,
   output logic [7:0]        req_count
);

   typedef enum logic [2:0] {IDLE, MOVA, MOVB, ALU, STR} state_t;

   state_t            state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic [7:0]        a_q, a_d, b_q, b_d;
   logic              store_q, store_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       instr_q, instr_d;
   logic              valid_q, valid_d;
   logic              ready_q, ready_d;
   logic              done_q, done_d;
   logic [7:0]        count_q, count_d;
   logic              xfer, last;

   function automatic logic [31:0] encode(state_t s, logic [1:0] op, logic [7:0] a,
                                          logic [7:0] b, logic [ADDR_W-1:0] addr);
      logic [3:0] cmd;
      logic [11:0] off;
      cmd = 4'b0100;
      case (op)
         2'b00:   cmd = 4'b0100;
         2'b01:   cmd = 4'b0010;
         2'b10:   cmd = 4'b0000;
         default: cmd = 4'b1100;
      endcase
      off = 12'(addr);
      case (s)
         MOVA:    encode = 32'hE3A01000 | {24'h0, a};
         MOVB:    encode = 32'hE3A02000 | {24'h0, b};
         // {cond, 00, I=0, cmd, S=0, Rn=R1, Rd=R3, shift=0, Rm=R2}
         ALU:     encode = {4'hE, 2'b00, 1'b0, cmd, 1'b0, 4'd1, 4'd3, 8'h00, 4'd2};
         STR:     encode = 32'hE5803000 | {20'h0, off};
         default: encode = 32'h0;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      store_d = store_q;
      addr_d  = addr_q;
      xfer    = valid_q & instr_ready;
      last    = 1'b0;
      case (state_q)
         IDLE: if (req_valid) begin
            state_d = MOVA;
            op_d    = req_op;
            a_d     = req_a;
            b_d     = req_b;
            store_d = req_store;
            addr_d  = req_addr;
         end
         MOVA: if (xfer) state_d = MOVB;
         MOVB: if (xfer) state_d = ALU;
         ALU: if (xfer) begin
            state_d = store_q ? STR : IDLE;
            last    = ~store_q;
         end
         STR: if (xfer) begin
            state_d = IDLE;
            last    = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      valid_d = (state_d != IDLE);
      ready_d = (state_d == IDLE);
      done_d  = last;
      count_d = count_q + {7'd0, last};
      // outputs are registered, so encode from the state being entered
      instr_d = encode(state_d, op_d, a_d, b_d, addr_d);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         op_q    <= 2'b00;
         a_q     <= 8'h00;
         b_q     <= 8'h00;
         store_q <= 1'b0;
         addr_q  <= '0;
         instr_q <= 32'h0;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         count_q <= 8'h00;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         store_q <= store_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         count_q <= count_d;
      end
   end

   assign req_ready   = ready_q;
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign done        = done_q;
   assign req_count   = count_q;

endmodule

// File: tb/tb_arm_instr_encoder.sv
// Directed bench for arm_instr_encoder: hand-computed ARM words, stalls, busy rejection,
// asynchronous mid-burst reset and a 256-burst back-to-back count wrap.
module tb_arm_instr_encoder;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [7:0]  req_a, req_b;
   logic        req_store;
   logic [7:0]  req_addr;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        done;
   logic [7:0]  req_count;

   int n_chk  = 0;
   int n_pass = 0;

   arm_instr_encoder #(.ADDR_W(8)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_store(req_store),
      .req_addr(req_addr), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .done(done), .req_count(req_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   // Present a request at a negedge; returns at the negedge of the first word cycle.
   task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic st, input logic [7:0] addr);
      req_op = op; req_a = a; req_b = b; req_store = st; req_addr = addr;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Hold the word for `stall` cycles with instr_ready low, then transfer it.
   task automatic word(input string tag, input logic [31:0] w, input int stall);
      instr_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
         chk({tag, "_hold"}, instr, w);
         @(negedge clk);
      end
      chk(tag, instr, w);
      chk({tag, "_vld"}, {31'd0, instr_valid}, 32'd1);
      chk({tag, "_rdy"}, {31'd0, req_ready}, 32'd0);
      instr_ready = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      reset_n = 1'b0; req_valid = 1'b0; instr_ready = 1'b0;
      req_op = 2'b00; req_a = 8'h00; req_b = 8'h00; req_store = 1'b0; req_addr = 8'h00;

      // reset with activity on inputs
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         req_valid = ~req_valid; instr_ready = ~instr_ready;
      end
      @(negedge clk);
      chk("rst_vld",   {31'd0, instr_valid}, 32'd0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_done",  {31'd0, done}, 32'd0);
      chk("rst_cnt",   {24'd0, req_count}, 32'd0);
      chk("rst_rdy",   {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0; instr_ready = 1'b1;
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_ready_noeffect", {31'd0, instr_valid}, 32'd0);
      chk("idle_cnt", {24'd0, req_count}, 32'd0);

      // ADD with store, no stalls
      send(2'b00, 8'h12, 8'h34, 1'b1, 8'h05);
      word("add_mova", 32'hE3A01012, 0);
      word("add_movb", 32'hE3A02034, 0);
      word("add_alu",  32'hE0813002, 0);
      word("add_str",  32'hE5803005, 0);
      chk("add_done", {31'd0, done}, 32'd1);
      chk("add_cnt",  {24'd0, req_count}, 32'd1);
      chk("add_idle", {31'd0, instr_valid}, 32'd0);
      @(negedge clk);
      chk("add_done_once", {31'd0, done}, 32'd0);

      // SUB no store, 3 stall cycles per word
      send(2'b01, 8'hFF, 8'h01, 1'b0, 8'h00);
      word("sub_mova", 32'hE3A010FF, 3);
      word("sub_movb", 32'hE3A02001, 3);
      word("sub_alu",  32'hE0413002, 3);
      chk("sub_done",  {31'd0, done}, 32'd1);
      chk("sub_nostr", {31'd0, instr_valid}, 32'd0);
      chk("sub_cnt",   {24'd0, req_count}, 32'd2);
      @(negedge clk);

      // AND with inputs changed while busy
      send(2'b10, 8'h55, 8'h0F, 1'b0, 8'h00);
      req_a = 8'hAA; req_b = 8'hF0; req_op = 2'b11; req_store = 1'b1; req_valid = 1'b1;
      word("and_mova", 32'hE3A01055, 1);
      req_valid = 1'b0;
      word("and_movb", 32'hE3A0200F, 0);
      req_valid = 1'b1;
      word("and_alu",  32'hE0013002, 2);
      req_valid = 1'b0;
      chk("and_done", {31'd0, done}, 32'd1);
      chk("and_cnt",  {24'd0, req_count}, 32'd3);
      @(negedge clk);
      chk("and_nostart", {31'd0, instr_valid}, 32'd0);

      // asynchronous reset while stalled in ALU
      send(2'b11, 8'h01, 8'h02, 1'b1, 8'h09);
      word("rmb_mova", 32'hE3A01001, 0);
      word("rmb_movb", 32'hE3A02002, 0);
      instr_ready = 1'b0;
      chk("rmb_alu", instr, 32'hE1813002);
      #2 reset_n = 1'b0;
      #1;
      chk("rmb_vld_async",   {31'd0, instr_valid}, 32'd0);
      chk("rmb_instr_async", instr, 32'h0);
      chk("rmb_cnt_clr",     {24'd0, req_count}, 32'd0);
      @(negedge clk);
      chk("rmb_nodone", {31'd0, done}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rmb_nodone2", {31'd0, done}, 32'd0);
      send(2'b11, 8'h03, 8'h04, 1'b0, 8'h00);
      word("orr_mova", 32'hE3A01003, 0);
      word("orr_movb", 32'hE3A02004, 0);
      word("orr_alu",  32'hE1813002, 0);
      chk("orr_done", {31'd0, done}, 32'd1);
      chk("orr_cnt",  {24'd0, req_count}, 32'd1);

      // 256 back-to-back ORR bursts from a fresh count
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      instr_ready = 1'b1;
      req_op = 2'b11; req_a = 8'h07; req_b = 8'h08; req_store = 1'b0;
      req_valid = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 256; k++) begin
         chk("b2b_mova", instr, 32'hE3A01007);
         @(negedge clk);
         chk("b2b_movb", instr, 32'hE3A02008);
         @(negedge clk);
         chk("b2b_alu", instr, 32'hE1813002);
         @(negedge clk);
         chk("b2b_bubble", {31'd0, instr_valid}, 32'd0);
         chk("b2b_done",   {31'd0, done}, 32'd1);
         chk("b2b_cnt",    {24'd0, req_count}, 32'((k + 1) % 256));
         if (k == 255) req_valid = 1'b0;
         @(negedge clk);
      end
      chk("wrap_cnt",  {24'd0, req_count}, 32'd0);
      chk("wrap_idle", {31'd0, instr_valid}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/arm_instr_encoder.md
# arm_instr_encoder

Sequenced instruction encoder that turns calculator operation requests into ARM machine words for the single-cycle datapath. The datapath's main decoder consumes exactly these words. Each accepted request becomes a fixed burst: two immediate MOVs, one register data-processing instruction, and an optional STR. Words are streamed over a valid/ready handshake. The block sits between the calculator keypad/control logic and the instruction-injection port of the processor.

## Interface

Parameters:
- `ADDR_W`, default 8: width of the store offset; zero-extended into imm12; legal range 1..12.

Ports:
- `clk`, input, 1: rising-edge clock.
- `reset_n`, input, 1: asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- `req_valid`, input, 1: request present.
- `req_ready`, output, 1: block can accept a request; high only in IDLE.
- `req_op`, input, 2: 00 ADD, 01 SUB, 10 AND, 11 ORR.
- `req_a`, input, 8: first operand, loaded into R1.
- `req_b`, input, 8: second operand, loaded into R2.
- `req_store`, input, 1: 1 appends STR R3 to the burst.
- `req_addr`, input, ADDR_W: STR immediate offset from R0.
- `instr`, output, 32: current machine word; 32'h0 when `instr_valid` is 0.
- `instr_valid`, output, 1: `instr` is valid.
- `instr_ready`, input, 1: consumer takes the word.
- `done`, output, 1: one-cycle pulse after the last word of a burst transfers.
- `req_count`, output, 8: number of completed bursts; wraps modulo 256.

## Operation

- A request is accepted on a rising edge with `req_valid & req_ready`. At acceptance, `req_op`, `req_a`, `req_b`, `req_store` and `req_addr` are latched; later input changes are ignored.
- The FSM has states IDLE, MOVA, MOVB, ALU, STR.
  - IDLE goes to MOVA on accept.
  - MOVA goes to MOVB on a word transfer.
  - MOVB goes to ALU on a word transfer.
  - ALU goes to STR on a transfer when the latched store bit is 1; otherwise it goes to IDLE.
  - STR goes to IDLE on a transfer.
- A word transfer is a rising edge with `instr_valid & instr_ready`.
- `instr_valid` is 1 in MOVA, MOVB, ALU and STR, and 0 in IDLE.
- Encodings (cond = 1110 always; see the encoding sketch after this list):
  - MOVA: MOV R1,#a = 32'hE3A010_00 | a.
  - MOVB: MOV R2,#b = 32'hE3A020_00 | b.
  - ALU, R3 = R1 op R2: ADD = E0813002, SUB = E0413002, AND = E0013002, ORR = E1813002.
  - STR: STR R3,[R0,#addr] = 32'hE5803000 | zero-extended addr.
- `done` pulses for exactly the one cycle following the last transfer. That cycle is already IDLE, so a new request may be accepted while `done` is high.
- `req_count` increments by 1 on that same edge.

Encoding sketch:
- Data-processing words use bit fields {cond, 00, I, cmd, S=0, Rn, Rd, operand2}. cmd is 1101 for MOV, 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR.
- MOV words use I=1, Rn=0 and rot=0.
- The ALU word uses I=0, Rn=R1, Rd=R3, shift=0 and Rm=R2.
- The STR word uses op=01, funct=011000 (immediate offset, P=1, U=1, B=0, W=0, L=0), Rn=R0 and Rd=R3.

## Timing

- Reset (asynchronous, while `reset_n`=0):
  - State is IDLE.
  - `instr_valid`=0 and `instr`=0.
  - `done`=0 and `req_count`=0.
  - `req_ready`=1.
- Latency: the first word is valid in the cycle after accept. With `instr_ready` held high, a burst is 3 words in 3 cycles without store, or 4 words in 4 cycles with store.
- Stall: while `instr_valid`=1 and `instr_ready`=0, `instr` and the state hold stable for any number of cycles.
- `instr_ready` asserted while `instr_valid`=0 has no effect.
- `req_valid` while busy is not accepted: `req_ready`=0, and the requester must hold the request.
- Back-to-back: a request held continuously is accepted on the edge ending the `done` cycle. Its MOVA word appears in the next cycle, which gives one idle bubble between bursts.
- Reset asserted mid-burst:
  - The state returns to IDLE immediately and `instr_valid` drops asynchronously.
  - No `done` pulse is produced and `req_count` clears.
  - The partial burst is discarded and not resumed.
- `req_count` wraps from 255 to 0 on the 256th completion.

## Test plan

- Reset check:
  - Stimulus: hold `reset_n`=0 while toggling `clk`, `req_valid` and `instr_ready`.
  - Required: `instr_valid`=0, `instr`=0, `done`=0, `req_count`=0, `req_ready`=1.
- ADD with store, consumer always ready:
  - Stimulus: a=8'h12, b=8'h34, op=00, store=1, addr=8'h05.
  - Required: over 4 consecutive cycles `instr` = E3A01012, E3A02034, E0813002, E5803005.
  - Then `done` is high for 1 cycle and `req_count`=1.
- SUB without store, with stalls:
  - Stimulus: a=8'hFF, b=8'h01, op=01, store=0; `instr_ready` low for 3 cycles on each word.
  - Required: each word is held stable while stalled.
  - Words are E3A010FF, E3A02001, E0413002.
  - After the third transfer `done` pulses and there is no STR word.
- Busy rejection:
  - Stimulus: during an AND burst, change `req_a`, `req_op` and `req_valid`.
  - Required: `req_ready`=0 throughout the burst.
  - Emitted words still reflect the original latched values, with the ALU word = E0013002.
- Reset mid-burst:
  - Stimulus: assert `reset_n`=0 asynchronously while in ALU with `instr_ready`=0.
  - Required: `instr_valid` falls within the same cycle and no `done` pulse is produced.
  - After release, the next ORR request emits E1813002 as its third word.
- Count wrap and back-to-back:
  - Stimulus: 256 ORR bursts with `req_valid` held high.
  - Required: exactly one bubble cycle between bursts, and `req_count` goes 255 to 0 on the last `done`.
